// File: rtl/stash_access_sequencer_pkg.sv
// ============================================================================
// Module : stash_access_sequencer_pkg
// Brief  : Shared ORAM constants: FSM encodings, clog2, path sizing, LFSR taps.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stash_access_sequencer_pkg;

  localparam int STWidth = 3;
  localparam int ORAMZ   = 4;

  typedef enum logic [STWidth-1:0] {
    ST_RESET     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_PATHREAD  = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int blocks_on_path(input int leaf_bits);
    return ORAMZ * (leaf_bits + 1);
  endfunction

  function automatic logic [31:0] tap(input int n);
    return 32'd1 << (n - 1);
  endfunction

  // Maximal-length Fibonacci tap sets, bit n-1 set for tap n
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] m;
    case (width)
      2:  m = tap(2)  | tap(1);
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = tap(width) | tap(width - 1);
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stash_access_sequencer_if.sv
// ============================================================================
// Module : stash_access_sequencer_if
// Brief  : Request / stash handshake bundle; slave = sequencer, master = peers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stash_access_sequencer_if #(
  parameter int ORAML = 31,
  parameter int ORAMU = 32
);
  logic             StashResetDone;
  logic             ReqValid;
  logic             ReqReady;
  logic [ORAMU-1:0] ReqPAddr;
  logic [ORAML-1:0] ReqLeaf;
  logic             StashAlmostFull;
  logic [ORAML-1:0] AccessLeaf;
  logic [ORAMU-1:0] AccessPAddr;
  logic             AccessIsDummy;
  logic             StartScanOperation;
  logic             PathReadStart;
  logic             BlockWriteComplete;
  logic             StartReadOperation;
  logic             BlockReadComplete;
  logic             AccessDone;
  logic             Busy;

  modport slave (
    input  StashResetDone, ReqValid, ReqPAddr, ReqLeaf, StashAlmostFull,
           BlockWriteComplete, BlockReadComplete,
    output ReqReady, AccessLeaf, AccessPAddr, AccessIsDummy, StartScanOperation,
           PathReadStart, StartReadOperation, AccessDone, Busy
  );

  modport master (
    output StashResetDone, ReqValid, ReqPAddr, ReqLeaf, StashAlmostFull,
           BlockWriteComplete, BlockReadComplete,
    input  ReqReady, AccessLeaf, AccessPAddr, AccessIsDummy, StartScanOperation,
           PathReadStart, StartReadOperation, AccessDone, Busy
  );
endinterface

`default_nettype wire

// File: rtl/stash_access_sequencer_lfsr.sv
// ============================================================================
// Module : StashLeafLFSR
// Brief  : Free-running maximal-length LFSR supplying dummy-access leaves.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module StashLeafLFSR
  import stash_access_sequencer_pkg::*;
#(
  parameter int Width = 31
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [Width-1:0] Value
);

  localparam logic [Width-1:0] Taps = Width'(lfsr_taps(Width));

  logic [Width-1:0] lfsr_q;
  logic [Width-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[Width-2:0], ^(lfsr_q & Taps)};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr_q <= Width'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/stash_access_sequencer.sv
// ============================================================================
// Module : stash_access_sequencer
// Brief  : Sequences one ORAM access: path read into stash, then writeback.
//          Define STASH_TIMING_DUMMY_EN for periodic idle dummy accesses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stash_access_sequencer
  import stash_access_sequencer_pkg::*;
#(
  parameter int ORAML         = 31,
  parameter int ORAMU         = 32,
  parameter int BlocksOnPath  = blocks_on_path(ORAML),
  parameter int DummyInterval = 64
) (
  input  logic                      Clock,
  input  logic                      Reset,
  stash_access_sequencer_if.slave   bus
);

  localparam int              CntW    = clog2(BlocksOnPath + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BlocksOnPath - 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ORAML-1:0] leaf_q, leaf_d;
  logic [ORAMU-1:0] paddr_q, paddr_d;
  logic             dummy_q, dummy_d;
  logic [ORAML-1:0] lfsr_value;
  logic             timer_dummy;

  StashLeafLFSR #(.Width(ORAML)) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .Value (lfsr_value)
  );

`ifdef STASH_TIMING_DUMMY_EN
  localparam int               IdleW    = (clog2(DummyInterval) > 0) ? clog2(DummyInterval) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(DummyInterval - 1);

  logic [IdleW-1:0] idle_q, idle_d;

  // IDLE always exits on the last count, so the counter cannot wrap
  always_comb begin
    idle_d = '0;
    if (state_q == ST_IDLE && state_d == ST_IDLE) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign timer_dummy = (state_q == ST_IDLE) && (idle_q == IdleLast) && !bus.ReqValid;
`else
  logic unused_dummy_interval;
  assign unused_dummy_interval = (DummyInterval != 0);
  assign timer_dummy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    leaf_d  = leaf_q;
    paddr_d = paddr_q;
    dummy_d = dummy_q;
    case (state_q)
      ST_RESET: if (bus.StashResetDone) state_d = ST_IDLE;
      ST_IDLE: begin
        // Stash pressure outranks a pending request
        if (bus.StashAlmostFull || timer_dummy) begin
          dummy_d = 1'b1;
          paddr_d = '0;
          leaf_d  = lfsr_value;
          state_d = ST_START;
        end else if (bus.ReqValid) begin
          dummy_d = 1'b0;
          paddr_d = bus.ReqPAddr;
          leaf_d  = bus.ReqLeaf;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_PATHREAD;
      ST_PATHREAD: begin
        if (bus.BlockWriteComplete) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = ST_WRITEBACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        if (bus.BlockReadComplete) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      leaf_q  <= '0;
      paddr_q <= '0;
      dummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      leaf_q  <= leaf_d;
      paddr_q <= paddr_d;
      dummy_q <= dummy_d;
    end
  end

  // Pulses are masked by Reset so an abandoned access never signals completion
  assign bus.ReqReady           = !Reset && (state_q == ST_IDLE) && bus.ReqValid && !bus.StashAlmostFull;
  assign bus.StartScanOperation = !Reset && (state_q == ST_START);
  assign bus.PathReadStart      = !Reset && (state_q == ST_START);
  assign bus.StartReadOperation = !Reset && (state_q == ST_PATHREAD) && bus.BlockWriteComplete &&
                                  (cnt_q == CntLast);
  assign bus.AccessDone         = !Reset && (state_q == ST_DONE);
  assign bus.Busy               = Reset || (state_q != ST_IDLE);
  assign bus.AccessLeaf         = leaf_q;
  assign bus.AccessPAddr        = paddr_q;
  assign bus.AccessIsDummy      = dummy_q;

endmodule

`default_nettype wire

// File: tb/tb_stash_access_sequencer.sv
// ============================================================================
// Module : tb_stash_access_sequencer
// Brief  : Directed self-checking bench for stash_access_sequencer (ORAML=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stash_access_sequencer;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_err;
  int   k;

  // Expected 4-bit LFSR states after k free-running cycles from seed 1
  logic [3:0] lfsr_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  stash_access_sequencer_if #(.ORAML(4), .ORAMU(32)) bus ();

  stash_access_sequencer #(
    .ORAML         (4),
    .ORAMU         (32),
    .BlocksOnPath  (20),
    .DummyInterval (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) begin
    if (Reset) k <= 0;
    else       k <= k + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_request(input logic [31:0] pa, input logic [3:0] lf);
    @(negedge Clock);
    bus.ReqValid = 1'b1; bus.ReqPAddr = pa; bus.ReqLeaf = lf;
    #1;
    check_eq("req_ready", bus.ReqReady, 1'b1);
    @(negedge Clock);
    bus.ReqValid = 1'b0;
    #1;
    check_eq("start_scan", bus.StartScanOperation, 1'b1);
    check_eq("path_read_start", bus.PathReadStart, 1'b1);
    check_eq("start_leaf", bus.AccessLeaf, lf);
    check_eq("start_paddr", bus.AccessPAddr, pa);
    check_eq("start_dummy", bus.AccessIsDummy, 1'b0);
  endtask

  // Entered at the START cycle; drives the path read and writeback to DONE
  task automatic finish_access(input logic [3:0] lf, input logic [31:0] pa, input logic dm);
    int srd_at, srd_n, done_n, rdy_n;
    srd_at = -1; srd_n = 0; done_n = 0; rdy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      bus.BlockWriteComplete = 1'b1;
      #1;
      if (bus.StartReadOperation) begin srd_n++; srd_at = i; end
      rdy_n += int'(bus.ReqReady);
    end
    @(negedge Clock);
    bus.BlockWriteComplete = 1'b1;
    #1;
    if (bus.StartReadOperation) srd_n++;
    check_eq("start_read_index", srd_at, 19);
    check_eq("start_read_count", srd_n, 1);
    bus.BlockWriteComplete = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      bus.BlockReadComplete = 1'b1;
      #1;
      done_n += int'(bus.AccessDone);
      rdy_n  += int'(bus.ReqReady);
    end
    @(negedge Clock);
    bus.BlockReadComplete = 1'b0;
    #1;
    rdy_n += int'(bus.ReqReady);
    check_eq("access_done", bus.AccessDone, 1'b1);
    check_eq("early_done", done_n, 0);
    check_eq("done_leaf", bus.AccessLeaf, lf);
    check_eq("done_paddr", bus.AccessPAddr, pa);
    check_eq("done_dummy", bus.AccessIsDummy, dm);
    check_eq("ready_while_busy", rdy_n, 0);
  endtask

  initial begin
    int         n;
    int         idle_n;
    logic       found;
    logic [3:0] exp_leaf;
    n_checks = 0;
    n_err    = 0;
    Reset = 1'b1;
    bus.StashResetDone = 1'b0; bus.ReqValid = 1'b1; bus.ReqPAddr = '0; bus.ReqLeaf = '0;
    bus.StashAlmostFull = 1'b0; bus.BlockWriteComplete = 1'b0; bus.BlockReadComplete = 1'b0;

    repeat (3) @(negedge Clock);
    #1;
    check_eq("rst_busy", bus.Busy, 1'b1);
    check_eq("rst_ready", bus.ReqReady, 1'b0);
    check_eq("rst_leaf", bus.AccessLeaf, 4'h0);
    check_eq("rst_paddr", bus.AccessPAddr, 32'h0);
    check_eq("rst_dummy", bus.AccessIsDummy, 1'b0);
    check_eq("rst_scan", bus.StartScanOperation, 1'b0);
    check_eq("rst_done", bus.AccessDone, 1'b0);
    bus.ReqValid = 1'b0;
    Reset = 1'b0;

    repeat (10) @(negedge Clock);
    #1;
    check_eq("wait_stash_busy", bus.Busy, 1'b1);
    bus.StashResetDone = 1'b1;
    @(negedge Clock);
    #1;
    check_eq("idle_busy", bus.Busy, 1'b0);

    start_request(32'h1234, 4'h5);
    finish_access(4'h5, 32'h1234, 1'b0);

    // Stray write completions while idle
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      bus.BlockWriteComplete = 1'b1;
      #1;
      n += int'(bus.StartReadOperation) + int'(bus.Busy);
    end
    bus.BlockWriteComplete = 1'b0;
    check_eq("idle_stray_write", n, 0);

    // Request held off during an access, served afterwards
    start_request(32'hBEEF, 4'hA);
    bus.ReqValid = 1'b1; bus.ReqPAddr = 32'h55; bus.ReqLeaf = 4'h3;
    finish_access(4'hA, 32'hBEEF, 1'b0);
    start_request(32'h55, 4'h3);
    finish_access(4'h3, 32'h55, 1'b0);

    // Almost-full beats a simultaneous request
    @(negedge Clock);
    bus.StashAlmostFull = 1'b1; bus.ReqValid = 1'b1; bus.ReqPAddr = 32'h777; bus.ReqLeaf = 4'h6;
    exp_leaf = lfsr_seq[k % 15];
    #1;
    check_eq("full_ready", bus.ReqReady, 1'b0);
    @(negedge Clock);
    bus.StashAlmostFull = 1'b0; bus.ReqValid = 1'b0;
    #1;
    check_eq("dummy_scan", bus.StartScanOperation, 1'b1);
    check_eq("dummy_flag", bus.AccessIsDummy, 1'b1);
    check_eq("dummy_paddr", bus.AccessPAddr, 32'h0);
    check_eq("dummy_leaf", bus.AccessLeaf, exp_leaf);
    finish_access(exp_leaf, 32'h0, 1'b1);

    // Reset in the middle of the path read
    start_request(32'h99, 4'h9);
    repeat (7) begin
      @(negedge Clock);
      bus.BlockWriteComplete = 1'b1;
    end
    @(negedge Clock);
    bus.BlockWriteComplete = 1'b0;
    Reset = 1'b1;
    #1;
    check_eq("midrst_done", bus.AccessDone, 1'b0);
    check_eq("midrst_busy", bus.Busy, 1'b1);
    @(negedge Clock);
    #1;
    check_eq("midrst_leaf", bus.AccessLeaf, 4'h0);
    check_eq("midrst_paddr", bus.AccessPAddr, 32'h0);
    check_eq("midrst_done2", bus.AccessDone, 1'b0);
    Reset = 1'b0;
    start_request(32'hABC, 4'hC);
    finish_access(4'hC, 32'hABC, 1'b0);

`ifdef STASH_TIMING_DUMMY_EN
    for (int rep = 0; rep < 2; rep++) begin
      idle_n = 0;
      found  = 1'b0;
      exp_leaf = 4'h0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge Clock);
        #1;
        if (bus.StartScanOperation) found = 1'b1;
        else if (!bus.Busy) begin
          idle_n++;
          exp_leaf = lfsr_seq[k % 15];
        end
      end
      check_eq("timer_idle_cycles", idle_n, 8);
      check_eq("timer_start_seen", found, 1'b1);
      check_eq("timer_dummy_flag", bus.AccessIsDummy, 1'b1);
      check_eq("timer_dummy_leaf", bus.AccessLeaf, exp_leaf);
      if (found) finish_access(exp_leaf, 32'h0, 1'b1);
    end
`else
    n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clock);
      #1;
      n += int'(bus.StartScanOperation) + int'(bus.Busy);
    end
    check_eq("no_timer_dummy", n, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
